seq_stage_ctrl: RTL

SEQ_STAGE_CTRL -- requirements
Module: seq_stage_ctrl

---
 rtl/seq_stage_ctrl_pkg.sv | 49 ++++
 rtl/seq_mem_wait_timer.sv | 40 ++++
 rtl/seq_stage_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/seq_stage_ctrl_pkg.sv
// Shared definitions for the sequential Y86-style stage controller:
// state encodings, instruction codes, status codes and opcode-class helpers.
package seq_stage_ctrl_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_FETCH     = 3'd1;
   localparam state_t ST_DECODE    = 3'd2;
   localparam state_t ST_EXECUTE   = 3'd3;
   localparam state_t ST_MEMORY    = 3'd4;
   localparam state_t ST_WRITEBACK = 3'd5;
   localparam state_t ST_PCUPD     = 3'd6;
   localparam state_t ST_HALT      = 3'd7;

   localparam logic [3:0] IC_HALT  = 4'h0;
   localparam logic [3:0] IC_NOP   = 4'h1;
   localparam logic [3:0] IC_CMOV  = 4'h2;
   localparam logic [3:0] IC_IRMOV = 4'h3;
   localparam logic [3:0] IC_RMMOV = 4'h4;
   localparam logic [3:0] IC_MRMOV = 4'h5;
   localparam logic [3:0] IC_OPQ   = 4'h6;
   localparam logic [3:0] IC_JXX   = 4'h7;
   localparam logic [3:0] IC_CALL  = 4'h8;
   localparam logic [3:0] IC_RET   = 4'h9;
   localparam logic [3:0] IC_PUSH  = 4'hA;
   localparam logic [3:0] IC_POP   = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   function automatic logic is_mem_op(input logic [3:0] ic);
      case (ic)
         IC_RMMOV, IC_MRMOV, IC_CALL, IC_RET, IC_PUSH, IC_POP: is_mem_op = 1'b1;
         default:                                               is_mem_op = 1'b0;
      endcase
   endfunction

   function automatic logic writes_rf(input logic [3:0] ic);
      case (ic)
         IC_CMOV, IC_IRMOV, IC_MRMOV, IC_OPQ,
         IC_CALL, IC_RET, IC_PUSH, IC_POP: writes_rf = 1'b1;
         default:                          writes_rf = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/seq_mem_wait_timer.sv
// Counts MEMORY-state cycles spent waiting for dmem_ready and flags the
// cycle in which the wait would reach MEM_TIMEOUT.
module seq_mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic wait_i,
   output logic expired_o
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (wait_i) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // This wait cycle is the MEM_TIMEOUT-th one: the controller must abort now.
   assign expired_o = wait_i && !clear_i && (cnt_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/seq_stage_ctrl.sv
// Sequential F/D/E/M/W/PC stage controller with status and retire count.
// Optional retire counter: define SEQ_STAGE_CTRL_RETIRE_CNT_EN.
module seq_stage_ctrl
   import seq_stage_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       icode,
   input  logic             instr_valid,
   input  logic             imem_error,
   input  logic             dmem_ready,
   input  logic             dmem_error,
   output logic [5:0]       stage_en,
   output logic             cc_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic             dmem_req,
   output logic [2:0]       stat,
   output logic [CNT_W-1:0] retired
);

   state_t     state_q, state_d;
   logic [2:0] stat_q, stat_d;
   logic [5:0] stage_en_q, stage_en_d;
   logic       cc_we_q, cc_we_d;
   logic       rf_we_q, rf_we_d;
   logic       pc_we_q, pc_we_d;
   logic       dmem_req_q, dmem_req_d;

   logic mem_op_s;
   logic wait_s;
   logic clear_s;
   logic expired_s;

   assign mem_op_s = is_mem_op(icode);
   assign clear_s  = (state_q != ST_MEMORY);
   assign wait_s   = (state_q == ST_MEMORY) && mem_op_s && !dmem_error && !dmem_ready;

   seq_mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_wait_timer (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (clear_s),
      .wait_i   (wait_s),
      .expired_o(expired_s)
   );

   always_comb begin
      state_d = state_q;
      stat_d  = stat_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
            else       state_d = ST_IDLE;
         end
         ST_FETCH: begin
            if (imem_error) begin
               state_d = ST_HALT;
               stat_d  = STAT_ADR;
            end else if (!instr_valid) begin
               state_d = ST_HALT;
               stat_d  = STAT_INS;
            end else begin
               state_d = ST_DECODE;
            end
         end
         ST_DECODE:  state_d = ST_EXECUTE;
         ST_EXECUTE: state_d = ST_MEMORY;
         ST_MEMORY: begin
            // A data fault beats a simultaneous ready.
            if (!mem_op_s) begin
               state_d = ST_WRITEBACK;
            end else if (dmem_error || expired_s) begin
               state_d = ST_HALT;
               stat_d  = STAT_ADR;
            end else if (dmem_ready) begin
               state_d = ST_WRITEBACK;
            end else begin
               state_d = ST_MEMORY;
            end
         end
         ST_WRITEBACK: state_d = ST_PCUPD;
         ST_PCUPD: begin
            if (icode == IC_HALT) begin
               state_d = ST_HALT;
               stat_d  = STAT_HLT;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: begin
            state_d = ST_IDLE;
            stat_d  = STAT_AOK;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      stage_en_d = 6'b000000;
      cc_we_d    = 1'b0;
      rf_we_d    = 1'b0;
      pc_we_d    = 1'b0;
      dmem_req_d = 1'b0;
      case (state_d)
         ST_FETCH:     stage_en_d = 6'b000001;
         ST_DECODE:    stage_en_d = 6'b000010;
         ST_EXECUTE: begin
            stage_en_d = 6'b000100;
            cc_we_d    = (icode == IC_OPQ);
         end
         ST_MEMORY: begin
            stage_en_d = 6'b001000;
            dmem_req_d = mem_op_s;
         end
         ST_WRITEBACK: begin
            stage_en_d = 6'b010000;
            rf_we_d    = writes_rf(icode);
         end
         ST_PCUPD: begin
            stage_en_d = 6'b100000;
            pc_we_d    = 1'b1;
         end
         default:      stage_en_d = 6'b000000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         stat_q     <= STAT_AOK;
         stage_en_q <= 6'b000000;
         cc_we_q    <= 1'b0;
         rf_we_q    <= 1'b0;
         pc_we_q    <= 1'b0;
         dmem_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         stat_q     <= stat_d;
         stage_en_q <= stage_en_d;
         cc_we_q    <= cc_we_d;
         rf_we_q    <= rf_we_d;
         pc_we_q    <= pc_we_d;
         dmem_req_q <= dmem_req_d;
      end
   end

   assign stage_en = stage_en_q;
   assign cc_we    = cc_we_q;
   assign rf_we    = rf_we_q;
   assign pc_we    = pc_we_q;
   assign dmem_req = dmem_req_q;
   assign stat     = stat_q;

`ifdef SEQ_STAGE_CTRL_RETIRE_CNT_EN
   logic [CNT_W-1:0] retired_q;

   // Every PCUPD cycle retires one instruction, halt included; wraps silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         retired_q <= '0;
      end else if (state_q == ST_PCUPD) begin
         retired_q <= retired_q + CNT_W'(1);
      end else begin
         retired_q <= retired_q;
      end
   end

   assign retired = retired_q;
`else
   assign retired = '0;
`endif

endmodule
